array_multiplier: RTL and testbench
===================================

Name: array_multiplier

Overview:
- Unsigned WIDTH x WIDTH array multiplier producing the full 2*WIDTH-bit product.
- Classic AND-gate partial-product array reduced by rows of full adders, with a final ripple row.
- The product is captured in an output register.
- Used as the exact binary reference multiplier alongside the stochastic-computing multiplier blocks (4-bit instance by default).

Parameters:
- WIDTH, 4, operand width in bits (valid range 2..16); product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; product register loads only when en=1.
- a  input  WIDTH  unsigned multiplicand.
- b  input  WIDTH  unsigned multiplier.
- z  output  2*WIDTH  registered unsigned product a*b.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset: z = 0 on the first clk edge with rst=1. rst has priority over en.
- Arithmetic:
  - pp[i][j] = a[j] & b[i].
  - Row 0 is pp[0]. Each following row i adds pp[i] shifted by i, using WIDTH full adders on carry-save sum/carry from the previous row.
  - A final WIDTH-bit ripple row resolves the remaining carries into the upper product bits.
  - The result equals a*b exactly, with no truncation. Maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits, so no overflow output exists.
- Operands are unsigned only; no sign extension.
- Latency: combinational path from a/b to the product register D input. z reflects a/b sampled at the clk edge where en=1 and rst=0: one cycle latency, visible after that edge.
- en=0: z holds its last value regardless of a/b changes.
- Back-to-back operation: new operands may be presented every cycle, throughput 1 per cycle.
- Reset mid-operation: the in-flight result is discarded; z = 0 until the next enabled capture.
- No X propagation: all array nodes are driven for every input combination.

Optional Feature:
- Macro: ARRAY_MUL_IN_REG_EN.
- Defined:
  - a and b are first registered into operand registers (loaded when en=1, cleared by rst).
  - The product register loads from the array output every cycle that en was high one cycle earlier, tracked by an internal 1-bit valid register that rst clears.
  - Total latency is 2 cycles from operand capture to z; z holds while the tracked valid is 0.
- Undefined: the single-register, 1-cycle-latency behaviour above.
- Port list is identical in both builds.

Decomposition:
- Package array_mul_pkg:
  - localparam ARRAY_MUL_DEF_WIDTH = 4.
  - Function prod_width(w) returning 2*w.
  - typedef for a 4-bit operand and an 8-bit product, for default-width users.
- Sub-module array_mul_fa: 1-bit full adder, inputs x, y, cin; outputs s, cout. The multiplier instantiates it in generate loops over rows and columns.
- A half adder is expressed as array_mul_fa with cin tied to 0; no separate module.

Test Plan:
- Reset: rst=1 for 2 cycles with a=15, b=15, en=1 -> z=0. Release rst -> z=225 one cycle later.
- Corners at WIDTH=4: (0,13)->0; (1,9)->9; (15,1)->15; (8,8)->64; (15,15)->225. Each checked one cycle after capture.
- Exhaustive WIDTH=4: all 256 (a,b) pairs, one per cycle with en=1 -> each z equals a*b on the following cycle; zero mismatches.
- Hold: capture (7,6) -> z=42; then en=0 while a/b change to (3,3) for 5 cycles -> z stays 42. Raise en -> z=9.
- Reset mid-stream: capture (12,11) and assert rst on the same edge -> z=0, not 132. Next enabled cycle with (12,11) -> z=132.
- WIDTH=8 build, with and without ARRAY_MUL_IN_REG_EN: (255,255)->65025 at 1 and 2 cycles latency respectively; 1000 random pairs match a*b.

Source files
------------

// File: rtl/array_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_mul_pkg
//  Description : Shared width constant, product-width helper and default-width
//                operand/product types for the array multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package array_mul_pkg;

    localparam int ARRAY_MUL_DEF_WIDTH = 4;

    typedef logic [ARRAY_MUL_DEF_WIDTH-1:0]   am_operand_t;
    typedef logic [2*ARRAY_MUL_DEF_WIDTH-1:0] am_product_t;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/array_mul_fa.sv
`default_nettype none
// ============================================================================
//  Module      : array_mul_fa
//  Description : One-bit full adder cell of the multiplier array.
//  Revision    : 1.0 - initial release
// ============================================================================
module array_mul_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule
`default_nettype wire

// File: rtl/array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : array_multiplier
//  Description : Unsigned WIDTH x WIDTH carry-save array multiplier with a
//                registered 2*WIDTH-bit product. Define ARRAY_MUL_IN_REG_EN to
//                add operand registers (2-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module array_multiplier
    import array_mul_pkg::*;
#(
    parameter int WIDTH = ARRAY_MUL_DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] z
);

    localparam int PW = prod_width(WIDTH);

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_load;
    logic [PW-1:0]    w_prod;
    logic             w_unused_cout;

`ifdef ARRAY_MUL_IN_REG_EN
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= en;
            if (en) begin
                r_a <= a;
                r_b <= b;
            end
        end
    end

    assign w_op_a = r_a;
    assign w_op_b = r_b;
    assign w_load = r_vld;
`else
    assign w_op_a = a;
    assign w_op_b = b;
    assign w_load = en;
`endif

    // Row i holds sum bits of weight i+j and carry bits of weight i+j+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        logic [WIDTH-1:0] pp;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;

        assign pp = w_op_a & {WIDTH{w_op_b[i]}};

        if (i == 0) begin : g_first
            assign s = pp;
            assign c = '0;
        end else begin : g_add
            for (genvar j = 0; j < WIDTH; j++) begin : g_col
                if (j < WIDTH - 1) begin : g_mid
                    array_mul_fa u_fa (
                        .x    (pp[j]),
                        .y    (g_row[i-1].s[j+1]),
                        .cin  (g_row[i-1].c[j]),
                        .s    (s[j]),
                        .cout (c[j])
                    );
                end else begin : g_msb
                    array_mul_fa u_fa (
                        .x    (pp[j]),
                        .y    (1'b0),
                        .cin  (g_row[i-1].c[j]),
                        .s    (s[j]),
                        .cout (c[j])
                    );
                end
            end
        end

        assign w_prod[i] = s[0];
    end

    for (genvar k = 0; k < WIDTH; k++) begin : g_fin
        logic xin;
        logic ci;
        logic sum;
        logic co;

        if (k < WIDTH - 1) begin : g_x
            assign xin = g_row[WIDTH-1].s[k+1];
        end else begin : g_x_top
            assign xin = 1'b0;
        end

        if (k == 0) begin : g_ci0
            assign ci = 1'b0;
        end else begin : g_cin
            assign ci = g_fin[k-1].co;
        end

        array_mul_fa u_fa (
            .x    (xin),
            .y    (g_row[WIDTH-1].c[k]),
            .cin  (ci),
            .s    (sum),
            .cout (co)
        );

        assign w_prod[WIDTH+k] = sum;
    end

    // The product always fits in 2*WIDTH bits, so the last carry is always 0.
    assign w_unused_cout = g_fin[WIDTH-1].co;

    always_ff @(posedge clk) begin
        if (rst) begin
            z <= '0;
        end else if (w_load) begin
            z <= w_prod;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_multiplier
//  Description : Self-checking bench for array_multiplier at WIDTH=4 and 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_array_multiplier;

`ifdef ARRAY_MUL_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [3:0]  a4  = '0;
    logic [3:0]  b4  = '0;
    logic [7:0]  z4;
    logic [7:0]  a8  = '0;
    logic [7:0]  b8  = '0;
    logic [15:0] z8;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    array_multiplier #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a4),
        .b   (b4),
        .z   (z4)
    );

    array_multiplier #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a8),
        .b   (b8),
        .z   (z8)
    );

    // Reference model: plain arithmetic on the operands seen at each edge.
    logic [7:0]  m_z4 = '0;
    logic [15:0] m_z8 = '0;
    logic [3:0]  m_a4 = '0, m_b4 = '0;
    logic [7:0]  m_a8 = '0, m_b8 = '0;
    logic        m_v  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_z4 = '0; m_z8 = '0; m_a4 = '0; m_b4 = '0;
            m_a8 = '0; m_b8 = '0; m_v = 1'b0;
        end else if (LAT == 2) begin
            if (m_v) begin
                m_z4 = 8'(m_a4) * 8'(m_b4);
                m_z8 = 16'(m_a8) * 16'(m_b8);
            end
            m_v = en;
            if (en) begin
                m_a4 = a4; m_b4 = b4; m_a8 = a8; m_b8 = b8;
            end
        end else if (en) begin
            m_z4 = 8'(a4) * 8'(b4);
            m_z8 = 16'(a8) * 16'(b8);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_checks++;
            if (z4 !== m_z4) begin
                n_fail++;
                $display("FAIL model4 t=%0t: z=%0d expected=%0d", $time, z4, m_z4);
            end
            n_checks++;
            if (z8 !== m_z8) begin
                n_fail++;
                $display("FAIL model8 t=%0t: z=%0d expected=%0d", $time, z8, m_z8);
            end
        end
    end

    task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic te, input logic tr);
        a4 = ta; b4 = tb; en = te; rst = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [3:0] ta, input logic [3:0] tb);
        step(ta, tb, 1'b1, 1'b0);
        if (LAT == 2) step(ta, tb, 1'b1, 1'b0);
    endtask

    task automatic check4(input string nm, input logic [7:0] exp);
        n_checks++;
        if (z4 !== exp) begin
            n_fail++;
            $display("FAIL %s: z=%0d expected=%0d", nm, z4, exp);
        end
    endtask

    task automatic check8(input string nm, input logic [15:0] exp);
        n_checks++;
        if (z8 !== exp) begin
            n_fail++;
            $display("FAIL %s: z=%0d expected=%0d", nm, z8, exp);
        end
    endtask

    logic [3:0] corner_a [5] = '{4'd0, 4'd1, 4'd15, 4'd8, 4'd15};
    logic [3:0] corner_b [5] = '{4'd13, 4'd9, 4'd1, 4'd8, 4'd15};
    logic [7:0] corner_z [5] = '{8'd0, 8'd9, 8'd15, 8'd64, 8'd225};

    initial begin
        // Reset held two cycles with live operands
        step(4'd15, 4'd15, 1'b1, 1'b1);
        chk_on = 1'b1;
        step(4'd15, 4'd15, 1'b1, 1'b1);
        check4("reset_z", 8'd0);
        check8("reset_z8", 16'd0);
        capture(4'd15, 4'd15);
        check4("post_reset_225", 8'd225);

        for (int i = 0; i < 5; i++) begin
            capture(corner_a[i], corner_b[i]);
            check4($sformatf("corner_%0dx%0d", corner_a[i], corner_b[i]), corner_z[i]);
        end

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                step(4'(i), 4'(j), 1'b1, 1'b0);

        // Hold with en low
        capture(4'd7, 4'd6);
        check4("hold_capture_42", 8'd42);
        for (int i = 0; i < 5; i++) begin
            step(4'd3, 4'd3, 1'b0, 1'b0);
            check4("hold_42", 8'd42);
        end
        capture(4'd3, 4'd3);
        check4("hold_release_9", 8'd9);

        // Reset wins over a simultaneous capture
        step(4'd12, 4'd11, 1'b1, 1'b1);
        check4("rst_mid_0", 8'd0);
        capture(4'd12, 4'd11);
        check4("rst_mid_132", 8'd132);

        a8 = 8'd255; b8 = 8'd255;
        capture(4'd2, 4'd3);
        check8("max8_65025", 16'd65025);
        check4("w4_2x3", 8'd6);

        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 7) != 0), 1'b0);
        end
        step(4'd0, 4'd0, 1'b0, 1'b0);
        step(4'd0, 4'd0, 1'b0, 1'b0);
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
